// File: rtl/sbqm_pkg.sv
// Shared widths, limits and the wait-time estimate for the bank queue manager.
package sbqm_pkg;

   localparam int                  PCOUNT_W     = 3;
   localparam int                  TCOUNT_W     = 2;
   localparam int                  WTIME_W      = 5;
   localparam logic [PCOUNT_W-1:0] PCOUNT_MAX   = 3'd7;
   localparam int                  SVC_TIME_DEF = 3;

   // Wait estimate: floor(svc*(P+T-1)/T), T = max(Tcount,1), 0 when queue empty.
   // T is only ever 1..3, so the divide is a mux of constant divides.
   function automatic logic [WTIME_W-1:0] wtime_calc(
      input logic [PCOUNT_W-1:0] pcount,
      input logic [TCOUNT_W-1:0] tcount,
      input int unsigned         svc
   );
      logic [TCOUNT_W-1:0] t;
      logic [5:0]          num;
      logic [5:0]          quo;
      t   = (tcount == '0) ? 2'd1 : tcount;
      num = 6'(svc) * (6'(pcount) + 6'(t) - 6'd1);
      case (t)
         2'd2:    quo = num >> 1;
         2'd3:    quo = num / 6'd3;
         default: quo = num;
      endcase
      if (pcount == '0) quo = '0;
      return quo[WTIME_W-1:0];
   endfunction

endpackage

// File: rtl/sbqm_edge_det.sv
// Sensor front end: SYNC_STAGES-flop synchronizer plus falling-edge pulse.
// All flops reset to the idle-high level so reset release never fakes an edge.
module sbqm_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic sensor_n,
   output logic fall_pulse
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   // Shift the raw pin through the chain; remember the last synchronized level.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sensor_n};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   // Synchronizer and edge-history flops, idle-high on reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign fall_pulse = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sbqm_queue_mgr.sv
// Single-bank queue manager: saturating customer counter driven by two
// active-low door sensors, full/empty flags and a wait-time estimate.
// Define SBQM_WTIME_REG_EN to register Wtime (one extra clk of latency).
module sbqm_queue_mgr
   import sbqm_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int SVC_TIME    = SVC_TIME_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                upSignal,
   input  logic                downSignal,
   input  logic [TCOUNT_W-1:0] Tcount,
   output logic [PCOUNT_W-1:0] Pcount,
   output logic [WTIME_W-1:0]  Wtime,
   output logic                fullFlag,
   output logic                emptyFlag
);

   logic [1:0]          pulse;   // [0] arrival, [1] departure
   logic                up, dn;
   logic [PCOUNT_W-1:0] pcount_q, pcount_d;
   logic [WTIME_W-1:0]  wtime_d;

   sbqm_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_det [1:0] (
      .clk        (clk),
      .reset      (reset),
      .sensor_n   ({downSignal, upSignal}),
      .fall_pulse (pulse)
   );

   assign up = pulse[0];
   assign dn = pulse[1];

   // Saturating up/down count; simultaneous arrival and departure cancel.
   always_comb begin
      pcount_d = pcount_q;
      if (up && !dn && pcount_q != PCOUNT_MAX)
         pcount_d = pcount_q + 3'd1;
      else if (dn && !up && pcount_q != '0)
         pcount_d = pcount_q - 3'd1;
   end

   // Queue length register.
   always_ff @(posedge clk) begin
      if (!reset) pcount_q <= '0;
      else        pcount_q <= pcount_d;
   end

   // Wait estimate from the registered count and the live teller count.
   always_comb begin
      wtime_d = wtime_calc(pcount_q, Tcount, SVC_TIME);
   end

`ifdef SBQM_WTIME_REG_EN
   logic [WTIME_W-1:0] wtime_q;

   // Registered wait estimate, one clk behind Pcount/Tcount.
   always_ff @(posedge clk) begin
      if (!reset) wtime_q <= '0;
      else        wtime_q <= wtime_d;
   end

   assign Wtime = wtime_q;
`else
   assign Wtime = wtime_d;
`endif

   assign Pcount    = pcount_q;
   assign fullFlag  = (pcount_q == PCOUNT_MAX);
   assign emptyFlag = (pcount_q == '0);

endmodule

// File: tb/tb_sbqm_queue_mgr.sv
// Directed bench for sbqm_queue_mgr (default SYNC_STAGES=2, SVC_TIME=3).
// Honors SBQM_WTIME_REG_EN when checking Wtime latency.
module tb_sbqm_queue_mgr;

   logic       clk = 1'b0;
   logic       reset;
   logic       upSignal;
   logic       downSignal;
   logic [1:0] Tcount;
   logic [2:0] Pcount;
   logic [4:0] Wtime;
   logic       fullFlag;
   logic       emptyFlag;

   int checks = 0;
   int errors = 0;

   sbqm_queue_mgr dut (
      .clk        (clk),
      .reset      (reset),
      .upSignal   (upSignal),
      .downSignal (downSignal),
      .Tcount     (Tcount),
      .Pcount     (Pcount),
      .Wtime      (Wtime),
      .fullFlag   (fullFlag),
      .emptyFlag  (emptyFlag)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Wtime right after a Tcount change inside a cycle: registered build
   // still shows the old value, combinational build already the new one.
   task automatic chk_wlat(input string tag, input int old_v, input int new_v);
`ifdef SBQM_WTIME_REG_EN
      chk(tag, Wtime, old_v);
`else
      chk(tag, Wtime, new_v);
`endif
   endtask

   task automatic pulse_up();
      upSignal = 1'b0; tick(3);
      upSignal = 1'b1; tick(3);
   endtask

   task automatic pulse_dn();
      downSignal = 1'b0; tick(3);
      downSignal = 1'b1; tick(3);
   endtask

   initial begin
      int exp_w [0:7];
      exp_w = '{0, 3, 6, 9, 12, 15, 18, 21};   // Tcount=1, SVC_TIME=3

      // 1: reset
      upSignal = 1'b1; downSignal = 1'b1; Tcount = 2'd1; reset = 1'b0;
      tick(2);
      chk("rst_pcount", Pcount, 0);
      chk("rst_empty", emptyFlag, 1);
      chk("rst_full", fullFlag, 0);
      chk("rst_wtime", Wtime, 0);
      reset = 1'b1;
      tick(3);
      chk("rel_pcount", Pcount, 0);

      // 2: arrivals; first one also checks the two-edge latency
      upSignal = 1'b0; tick(2);
      chk("lat_before", Pcount, 0);
      tick(1);
      chk("lat_at", Pcount, 1);
      upSignal = 1'b1; tick(3);
      chk("wt_p1", Wtime, 3);
      for (int i = 2; i <= 8; i++) begin
         pulse_up();
         chk("up_pcount", Pcount, (i > 7) ? 7 : i);
         chk("up_wtime", Wtime, exp_w[(i > 7) ? 7 : i]);
      end
      chk("full_at7", fullFlag, 1);
      chk("empty_at7", emptyFlag, 0);

      // 3: teller sweep at Pcount=7
      Tcount = 2'd0; #1; chk_wlat("t0_lat", 21, 21); tick(1); chk("t0_w", Wtime, 21);
      Tcount = 2'd1; #1; chk_wlat("t1_lat", 21, 21); tick(1); chk("t1_w", Wtime, 21);
      Tcount = 2'd2; #1; chk_wlat("t2_lat", 21, 12); tick(1); chk("t2_w", Wtime, 12);
      Tcount = 2'd3; #1; chk_wlat("t3_lat", 12, 9);  tick(1); chk("t3_w", Wtime, 9);
      Tcount = 2'd1; tick(2);

      // 4: departures, 8th ignored at 0
      for (int i = 6; i >= -1; i--) begin
         pulse_dn();
         chk("dn_pcount", Pcount, (i < 0) ? 0 : i);
         chk("dn_wtime", Wtime, exp_w[(i < 0) ? 0 : i]);
      end
      chk("empty_at0", emptyFlag, 1);
      chk("full_at0", fullFlag, 0);

      // 5: simultaneous edges at Pcount=4
      repeat (4) pulse_up();
      chk("pre_sim", Pcount, 4);
      Tcount = 2'd3;
      upSignal = 1'b0; downSignal = 1'b0; tick(3);
      upSignal = 1'b1; downSignal = 1'b1; tick(3);
      chk("sim_pcount", Pcount, 4);
      chk("sim_wtime", Wtime, 6);

      // 6: held-low sensor counts once
      upSignal = 1'b0; tick(20);
      chk("hold_low", Pcount, 5);
      upSignal = 1'b1; tick(4);
      chk("hold_rel", Pcount, 5);
      chk("hold_wt", Wtime, 7);                // floor(3*7/3)

      // reset mid-queue with an arrival edge still in the synchronizer
      upSignal = 1'b0; tick(1);
      reset = 1'b0; upSignal = 1'b1; tick(1);
      chk("mid_rst_p", Pcount, 0);
      chk("mid_rst_e", emptyFlag, 1);
      chk("mid_rst_w", Wtime, 0);
      reset = 1'b1; tick(5);
      chk("post_rst_p", Pcount, 0);
      pulse_up();
      chk("post_rst_up", Pcount, 1);
      chk("post_rst_w", Wtime, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
